// File: rtl/uart_mem_server.sv
// rtl/uart_mem_server.sv - UART 8N1 word read/write memory responder
// Receives read/write request frames on Rx, executes them on a local RAM, answers on Tx.
module uart_mem_server #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Rx,
    output logic        Tx,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] req_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {CMD, ADDR, DATA, EXEC, RESP} p_state_t;

    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t       r_rx_state, w_rx_next;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift, r_rx_byte;
    logic            r_rx_valid, r_rx_err;
    logic            w_rx_tick, w_rx_half;

    p_state_t        r_state, w_state_next;
    logic [1:0]      r_cnt;
    logic            r_is_write;
    logic [31:0]     r_addr, r_data, w_addr_next;
    logic [15:0]     r_req_count;
    logic            w_frame_err, w_last_byte, w_cmd_ok;

    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [31:0]           r_ram_q;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_we;

    logic            r_tx, r_tx_active;
    logic [CW-1:0]   r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [2:0]      r_tx_left;
    logic [31:0]     r_tx_shift;
    logic            w_tx_tick, w_tx_done;
    logic            w_unused;

    assign w_rx_tick = (r_rx_cnt == C_LAST);
    assign w_rx_half = (r_rx_cnt == C_HALF);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // The deserializer never looks at the parser state, so bit alignment survives dropped bytes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_meta  <= Rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_next;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_rx_tick)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_state == RX_START)
                r_rx_bit <= '0;
            if (r_rx_state == RX_DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (r_rx_state == RX_STOP && w_rx_tick) begin
                if (r_rx_sync) begin
                    r_rx_valid <= 1'b1;
                    r_rx_byte  <= r_rx_shift;
                end else begin
                    r_rx_err   <= 1'b1;
                end
            end
        end
    end

    assign w_addr_next = {r_rx_byte, r_addr[31:8]};
    assign w_last_byte = r_rx_valid && (r_cnt == 2'd3);
    assign w_cmd_ok    = (r_rx_byte == 8'h01) || (r_rx_byte == 8'h02);

    always_comb begin
        w_state_next = r_state;
        w_frame_err  = 1'b0;
        case (r_state)
            CMD: begin
                if (r_rx_err) begin
                    w_frame_err = 1'b1;
                end else if (r_rx_valid) begin
                    if (w_cmd_ok) w_state_next = ADDR;
                    else          w_frame_err  = 1'b1;
                end
            end
            ADDR: begin
                if (r_rx_err) begin
                    w_frame_err  = 1'b1;
                    w_state_next = CMD;
                end else if (w_last_byte) begin
                    w_state_next = r_is_write ? DATA : EXEC;
                end
            end
            DATA: begin
                if (r_rx_err) begin
                    w_frame_err  = 1'b1;
                    w_state_next = CMD;
                end else if (w_last_byte) begin
                    w_state_next = EXEC;
                end
            end
            EXEC:    w_state_next = RESP;
            RESP:    if (w_tx_done) w_state_next = CMD;
            default: w_state_next = CMD;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= CMD;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_req_count <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                CMD: if (r_rx_valid) begin
                    r_is_write <= (r_rx_byte == 8'h02);
                    r_cnt      <= '0;
                end
                ADDR: if (r_rx_valid) begin
                    r_addr <= w_addr_next;
                    r_cnt  <= r_cnt + 2'd1;
                end
                DATA: if (r_rx_valid) begin
                    r_data <= {r_rx_byte, r_data[31:8]};
                    r_cnt  <= r_cnt + 2'd1;
                end
                EXEC:    r_req_count <= r_req_count + 16'd1;
                default: ;
            endcase
        end
    end

    // Read address is presented while the last address byte is accepted so data is ready in EXEC.
    assign w_ram_idx = (r_state == EXEC) ? r_addr[ADDR_WIDTH+1:2] : w_addr_next[ADDR_WIDTH+1:2];
    assign w_ram_we  = (r_state == EXEC) && r_is_write;

    always_ff @(posedge CLK) begin
        if (w_ram_we)
            r_mem[w_ram_idx] <= r_data;
        r_ram_q <= r_mem[w_ram_idx];
    end

    assign w_tx_tick = r_tx_active && (r_tx_cnt == C_LAST);
    assign w_tx_done = w_tx_tick && (r_tx_bit == 4'd9) && (r_tx_left == 3'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_left   <= '0;
            r_tx_shift  <= '0;
        end else if (r_state == EXEC) begin
            r_tx        <= 1'b0;
            r_tx_active <= 1'b1;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_left   <= r_is_write ? 3'd1 : 3'd4;
            r_tx_shift  <= r_is_write ? 32'h0000_00A5 : r_ram_q;
        end else if (r_tx_active) begin
            if (r_tx_cnt != C_LAST) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end else begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    if (r_tx_left == 3'd1) begin
                        r_tx_active <= 1'b0;
                    end else begin
                        r_tx_left  <= r_tx_left - 3'd1;
                        r_tx_shift <= {8'h00, r_tx_shift[31:8]};
                        r_tx_bit   <= '0;
                        r_tx       <= 1'b0;
                    end
                end else begin
                    r_tx_bit <= r_tx_bit + 4'd1;
                    r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_shift[r_tx_bit[2:0]];
                end
            end
        end
    end

    assign w_unused  = ^{r_addr, w_addr_next};
    assign Tx        = r_tx;
    assign frame_err = w_frame_err;
    assign busy      = (r_state == EXEC) || (r_state == RESP) || (w_state_next == EXEC);
    assign req_count = r_req_count;

endmodule
